// File: rtl/rom_arb_pkg.sv
// Shared constants, ROM contents and index helpers for the ROM access arbiter.
package rom_arb_pkg;

   localparam int ROM_DEPTH  = 8;
   localparam int DEF_IDX_W  = 3;
   localparam int DEF_DATA_W = 8;

   // Entry i lives at bits [i*8 +: 8].
   localparam logic [ROM_DEPTH*DEF_DATA_W-1:0] ROM_DATA = {
      8'hDD, 8'hEE, 8'hFF, 8'hAF, 8'hCC, 8'h21, 8'h12, 8'h10
   };

   function automatic logic [ROM_DEPTH-1:0] idx_to_onehot(input logic [DEF_IDX_W-1:0] idx);
      return 8'd1 << idx;
   endfunction

endpackage

// File: rtl/rom_access_arbiter_rr.sv
// Combinational round-robin arbiter: scans req starting at ptr and returns the
// one-hot grant plus the pointer value to load when that grant is taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] ptr_nxt
);
   localparam int PTR_W = $clog2(N);

   logic found;
   int   cand;

   // Rotating priority scan; the first valid requester from ptr onward wins.
   always_comb begin
      gnt     = {N{1'b0}};
      ptr_nxt = ptr;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!found && req[cand[PTR_W-1:0]]) begin
            gnt[cand[PTR_W-1:0]] = 1'b1;
            ptr_nxt              = PTR_W'((cand + 1) % N);
            found                = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one registered-output, one-hot-addressed ROM between NUM_REQ requesters
// with a 3-stage valid/tag pipeline routing each response back to its requester.
module rom_access_arbiter
   import rom_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rom_en,
   output logic [ROM_DEPTH-1:0]     rom_address,
   input  logic [DATA_W-1:0]        rom_data_out
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_nxt;
   logic [NUM_REQ-1:0]   gnt;
   logic [IDX_W-1:0]     sel_idx;
   logic                 accept;

   // Stage 1 valid is rom_en itself; its tag travels alongside.
   logic                 rom_en_q, rom_en_d;
   logic [ROM_DEPTH-1:0] rom_address_q, rom_address_d;
   logic [NUM_REQ-1:0]   s1_tag_q, s1_tag_d;
   logic                 s2_vld_q, s2_vld_d;
   logic [NUM_REQ-1:0]   s2_tag_q, s2_tag_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .ptr_nxt (ptr_nxt)
   );

   assign req_ready   = rst ? {NUM_REQ{1'b0}} : gnt;
   assign accept      = |req_ready;
   assign rom_en      = rom_en_q;
   assign rom_address = rom_address_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;

   // Next-state for the pointer and every pipeline stage.
   always_comb begin
      sel_idx = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_idx = sel_idx | (req_idx[i*IDX_W +: IDX_W] & {IDX_W{gnt[i]}});
      end
      ptr_d         = accept ? ptr_nxt : ptr_q;
      rom_en_d      = accept;
      rom_address_d = accept ? idx_to_onehot(sel_idx) : 8'h00;
      s1_tag_d      = req_ready;
      s2_vld_d      = rom_en_q;
      s2_tag_d      = s1_tag_q;
      rsp_valid_d   = s2_vld_q ? s2_tag_q : {NUM_REQ{1'b0}};
      rsp_data_d    = s2_vld_q ? rom_data_out : {DATA_W{1'b0}};
   end

   // State registers; reset discards everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q         <= {PTR_W{1'b0}};
         rom_en_q      <= 1'b0;
         rom_address_q <= 8'h00;
         s1_tag_q      <= {NUM_REQ{1'b0}};
         s2_vld_q      <= 1'b0;
         s2_tag_q      <= {NUM_REQ{1'b0}};
         rsp_valid_q   <= {NUM_REQ{1'b0}};
         rsp_data_q    <= {DATA_W{1'b0}};
      end else begin
         ptr_q         <= ptr_d;
         rom_en_q      <= rom_en_d;
         rom_address_q <= rom_address_d;
         s1_tag_q      <= s1_tag_d;
         s2_vld_q      <= s2_vld_d;
         s2_tag_q      <= s2_tag_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Round-robin arbiter that shares the single 8-entry, one-hot-addressed, registered-output ROM between `NUM_REQ` requesters. Each requester presents a 3-bit entry index with a valid/ready handshake. The block converts the index to the ROM's one-hot address, drives the ROM enable, and routes the ROM's output back to the originating requester. It sits directly in front of the ROM and is the only driver of the ROM's `en` and `address` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_W`, 3: entry index width; the ROM has 2**IDX_W = 8 entries.
- `DATA_W`, 8: ROM data width.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_idx`  in  NUM_REQ*IDX_W  packed entry indices; requester i occupies bits [i*IDX_W +: IDX_W].
- `req_ready`  out  NUM_REQ  one-hot or zero; request accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  one-hot or zero; response strobe for requester i.
- `rsp_data`  out  DATA_W  response data; meaningful only while any `rsp_valid` bit is high.
- `rom_en`  out  1  drives the ROM `en` input.
- `rom_address`  out  8  drives the ROM one-hot `address` input.
- `rom_data_out`  in  DATA_W  from the ROM `data_out` output. The ROM registers its output, so it responds one cycle after `en`/`address`, and returns 0 when `en` is low.

## Operation
- Arbitration is combinational in the accept cycle:
  - Scan starts at pointer `ptr`, initialised to 0 at reset.
  - The first requester i with `req_valid[i]` set gets `req_ready[i]=1`.
  - After a grant to i, `ptr <= (i+1) mod NUM_REQ`.
  - `ptr` is unchanged when nothing is granted.
- Exactly one grant per cycle at most. `req_ready` never asserts for a requester whose `req_valid` is low.
- Requester obligation: `req_idx[i]` is held stable while `req_valid[i]` is high and not yet accepted. The arbiter does not check this.
- Pipeline. Each stage carries a valid bit and a NUM_REQ-bit one-hot tag.
  - S1, registered at the end of the accept cycle: `rom_en<=1`, `rom_address<=1<<idx`, tag.
  - S2: the ROM registers its data; the tag moves forward.
  - S3: `rsp_data<=rom_data_out`, `rsp_valid<=tag`.
- With no accept: `rom_en<=0` and `rom_address<=0`. Bubbles propagate, and `rsp_valid` is 0 in the matching cycle.
- There is no response backpressure. Requesters must sink `rsp_valid` unconditionally.
- Fully pipelined: one accept per cycle is sustained. The pipeline never stalls and there are no state-machine states beyond the pointer and the pipeline valids.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.

## Timing
- Reset values: `rom_en=0`, `rom_address=8'h00`, `rsp_valid=0`, `rsp_data=0`, `ptr=0`, all pipeline valids 0. `req_ready` is forced to 0 while `rst` is high.
- Latency: a request accepted in cycle T yields `rsp_valid` and `rsp_data` in cycle T+3, held for exactly one cycle.
- Back-to-back accepts in T, T+1, T+2 yield responses in T+3, T+4, T+5, in accept order.
- Reset asserted mid-flight: all in-flight requests are discarded, with no response ever issued. The first accept is possible in the first cycle after `rst` deasserts.
- Simultaneous request and response for the same requester is legal and independent.

## Structure
- Shared package `rom_arb_pkg` holds:
  - constants `ROM_DEPTH=8`, default `IDX_W` and `DATA_W`;
  - function `idx_to_onehot(idx)` returning the 8-bit one-hot address;
  - the ROM contents as constants, for the bench scoreboard. The contents are 10, 12, 21, CC, AF, FF, EE, DD (hex) for entries 0..7.
- One sub-module: `rr_arbiter` (parameter N). Inputs are `req` and `ptr`; outputs are the one-hot `gnt` and the next-pointer value. It is purely combinational; the top level registers `ptr`.
- The top level holds the 3-stage valid/tag shift register and the output registers.

## Test plan
- Single request: requester 2 asserts idx=3 at T → `req_ready[2]=1` at T, `rom_en=1` and `rom_address=08` at T+1, `rsp_valid=0100` and `rsp_data=CC` at T+3.
- All four requesters valid at once with idx 0,1,2,3, held until accepted → grants go 0,1,2,3 in consecutive cycles, responses 10,12,21,CC to requesters 0..3 at T+3..T+6.
- Continuous contention from requesters 1 and 3 for 8 cycles → grants alternate 1,3,1,3…; neither waits more than 1 cycle between grants.
- Idle bus: no `req_valid` for 5 cycles → `rom_en=0`, `rom_address=00`, `rsp_valid=0` throughout, and `ptr` is unchanged.
- Reset mid-flight: accept idx=5 and idx=7 at T and T+1, assert `rst` at T+2 → no `rsp_valid` ever appears, and all outputs are 0 during reset. After release, a new idx=4 request returns AF 3 cycles after accept.
- Full index sweep: requester 0 issues idx 0..7 back-to-back → `rom_address` walks 01→80, and `rsp_data` returns 10,12,21,CC,AF,FF,EE,DD on consecutive cycles.
